// File: rtl/id_ex_shift_pipe_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | id_ex_shift_pipe_if : ID-side, forwarding and EX-side signal bundle    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface id_ex_shift_pipe_if;
  logic        id_valid;
  logic [5:0]  id_funct;
  logic [4:0]  id_shamt;
  logic [4:0]  id_rs_num;
  logic [4:0]  id_rt_num;
  logic [4:0]  id_rd;
  logic [31:0] id_rs_val;
  logic [31:0] id_rt_val;
  logic        ex_stall;
  logic        flush;
  logic        exm_wen;
  logic [4:0]  exm_rd;
  logic [31:0] exm_data;
  logic        mwb_wen;
  logic [4:0]  mwb_rd;
  logic [31:0] mwb_data;
  logic        ex_valid;
  logic [31:0] ex_a;
  logic [4:0]  ex_b;
  logic [1:0]  ex_aluc;
  logic [4:0]  ex_rd;
  logic        ex_wen;
  logic        ex_illegal;

  modport master (
    output id_valid, id_funct, id_shamt, id_rs_num, id_rt_num, id_rd,
           id_rs_val, id_rt_val, ex_stall, flush,
           exm_wen, exm_rd, exm_data, mwb_wen, mwb_rd, mwb_data,
    input  ex_valid, ex_a, ex_b, ex_aluc, ex_rd, ex_wen, ex_illegal
  );

  modport slave (
    input  id_valid, id_funct, id_shamt, id_rs_num, id_rt_num, id_rd,
           id_rs_val, id_rt_val, ex_stall, flush,
           exm_wen, exm_rd, exm_data, mwb_wen, mwb_rd, mwb_data,
    output ex_valid, ex_a, ex_b, ex_aluc, ex_rd, ex_wen, ex_illegal
  );
endinterface
`default_nettype wire

// File: rtl/id_ex_shift_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | id_ex_shift_pipe : ID/EX register for shift-class R-type instructions |
// | Optional operand forwarding enabled by `define SHIFT_FWD_EN           |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module id_ex_shift_pipe (
  input  wire logic        clk,
  input  wire logic        rst,
  id_ex_shift_pipe_if.slave bus
);

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  localparam logic [1:0] ALUC_SLL = 2'b10;
  localparam logic [1:0] ALUC_SRL = 2'b01;
  localparam logic [1:0] ALUC_SRA = 2'b00;

  logic [31:0] rs_res;
  logic [31:0] rt_res;

`ifdef SHIFT_FWD_EN
  // EX/MEM beats MEM/WB; register 0 is hard-wired and never forwards.
  always_comb begin
    rs_res = bus.id_rs_val;
    if (bus.exm_wen && bus.exm_rd == bus.id_rs_num && bus.id_rs_num != 5'd0)
      rs_res = bus.exm_data;
    else if (bus.mwb_wen && bus.mwb_rd == bus.id_rs_num && bus.id_rs_num != 5'd0)
      rs_res = bus.mwb_data;
  end

  always_comb begin
    rt_res = bus.id_rt_val;
    if (bus.exm_wen && bus.exm_rd == bus.id_rt_num && bus.id_rt_num != 5'd0)
      rt_res = bus.exm_data;
    else if (bus.mwb_wen && bus.mwb_rd == bus.id_rt_num && bus.id_rt_num != 5'd0)
      rt_res = bus.mwb_data;
  end
`else
  assign rs_res = bus.id_rs_val;
  assign rt_res = bus.id_rt_val;

  logic unused_fwd;
  assign unused_fwd = ^{bus.exm_wen, bus.exm_rd, bus.exm_data,
                        bus.mwb_wen, bus.mwb_rd, bus.mwb_data,
                        bus.id_rs_num, bus.id_rt_num};
`endif

  // Variable shifts consume only the low five bits of the resolved rs.
  logic unused_rs_hi;
  assign unused_rs_hi = ^rs_res[31:5];

  logic        legal;
  logic        use_rs;
  logic [1:0]  dec_aluc;
  logic [4:0]  dec_amt;

  always_comb begin
    legal    = 1'b1;
    use_rs   = 1'b0;
    dec_aluc = ALUC_SRA;
    case (bus.id_funct)
      FUNCT_SLL:  dec_aluc = ALUC_SLL;
      FUNCT_SRL:  dec_aluc = ALUC_SRL;
      FUNCT_SRA:  dec_aluc = ALUC_SRA;
      FUNCT_SLLV: begin dec_aluc = ALUC_SLL; use_rs = 1'b1; end
      FUNCT_SRLV: begin dec_aluc = ALUC_SRL; use_rs = 1'b1; end
      FUNCT_SRAV: begin dec_aluc = ALUC_SRA; use_rs = 1'b1; end
      default:    legal = 1'b0;
    endcase
    dec_amt = use_rs ? rs_res[4:0] : bus.id_shamt;
  end

  logic        ex_valid_q,   ex_valid_d;
  logic [31:0] ex_a_q,       ex_a_d;
  logic [4:0]  ex_b_q,       ex_b_d;
  logic [1:0]  ex_aluc_q,    ex_aluc_d;
  logic [4:0]  ex_rd_q,      ex_rd_d;
  logic        ex_wen_q,     ex_wen_d;
  logic        ex_illegal_q, ex_illegal_d;

  always_comb begin
    // Default is HOLD; the illegal pulse never survives a hold.
    ex_valid_d   = ex_valid_q;
    ex_a_d       = ex_a_q;
    ex_b_d       = ex_b_q;
    ex_aluc_d    = ex_aluc_q;
    ex_rd_d      = ex_rd_q;
    ex_wen_d     = ex_wen_q;
    ex_illegal_d = 1'b0;
    if (bus.flush || !bus.ex_stall) begin
      ex_valid_d = 1'b0;
      ex_a_d     = 32'd0;
      ex_b_d     = 5'd0;
      ex_aluc_d  = 2'd0;
      ex_rd_d    = 5'd0;
      ex_wen_d   = 1'b0;
      if (!bus.flush && bus.id_valid) begin
        if (legal) begin
          ex_valid_d = 1'b1;
          ex_a_d     = rt_res;
          ex_b_d     = dec_amt;
          ex_aluc_d  = dec_aluc;
          ex_rd_d    = bus.id_rd;
          ex_wen_d   = (bus.id_rd != 5'd0);
        end else begin
          ex_illegal_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_a_q       <= 32'd0;
      ex_b_q       <= 5'd0;
      ex_aluc_q    <= 2'd0;
      ex_rd_q      <= 5'd0;
      ex_wen_q     <= 1'b0;
      ex_illegal_q <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_a_q       <= ex_a_d;
      ex_b_q       <= ex_b_d;
      ex_aluc_q    <= ex_aluc_d;
      ex_rd_q      <= ex_rd_d;
      ex_wen_q     <= ex_wen_d;
      ex_illegal_q <= ex_illegal_d;
    end
  end

  assign bus.ex_valid   = ex_valid_q;
  assign bus.ex_a       = ex_a_q;
  assign bus.ex_b       = ex_b_q;
  assign bus.ex_aluc    = ex_aluc_q;
  assign bus.ex_rd      = ex_rd_q;
  assign bus.ex_wen     = ex_wen_q;
  assign bus.ex_illegal = ex_illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_shift_pipe.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_id_ex_shift_pipe : scoreboard bench for id_ex_shift_pipe           |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_id_ex_shift_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_shift_pipe_if bus ();
  id_ex_shift_pipe dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic        valid;
    logic [31:0] a;
    logic [4:0]  b;
    logic [1:0]  aluc;
    logic [4:0]  rd;
    logic        wen;
    logic        illegal;
  } exp_t;

  exp_t cur;
  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    check_val({tag, ".valid"},   {31'd0, bus.ex_valid},   {31'd0, e.valid});
    check_val({tag, ".a"},       bus.ex_a,                e.a);
    check_val({tag, ".b"},       {27'd0, bus.ex_b},       {27'd0, e.b});
    check_val({tag, ".aluc"},    {30'd0, bus.ex_aluc},    {30'd0, e.aluc});
    check_val({tag, ".rd"},      {27'd0, bus.ex_rd},      {27'd0, e.rd});
    check_val({tag, ".wen"},     {31'd0, bus.ex_wen},     {31'd0, e.wen});
    check_val({tag, ".illegal"}, {31'd0, bus.ex_illegal}, {31'd0, e.illegal});
  endtask

  function automatic logic [31:0] resolve(input logic [4:0] num, input logic [31:0] rf);
`ifdef SHIFT_FWD_EN
    if (bus.exm_wen && bus.exm_rd == num && num != 5'd0) return bus.exm_data;
    if (bus.mwb_wen && bus.mwb_rd == num && num != 5'd0) return bus.mwb_data;
`endif
    return rf;
  endfunction

  function automatic exp_t model(input exp_t c);
    exp_t        n;
    logic [31:0] rs;
    logic [31:0] rt;
    n  = '0;
    rs = resolve(bus.id_rs_num, bus.id_rs_val);
    rt = resolve(bus.id_rt_num, bus.id_rt_val);
    if (bus.flush) return n;
    if (bus.ex_stall) begin
      n = c;
      n.illegal = 1'b0;
      return n;
    end
    if (!bus.id_valid) return n;
    case (bus.id_funct)
      6'h00: begin n.aluc = 2'b10; n.b = bus.id_shamt; end
      6'h02: begin n.aluc = 2'b01; n.b = bus.id_shamt; end
      6'h03: begin n.aluc = 2'b00; n.b = bus.id_shamt; end
      6'h04: begin n.aluc = 2'b10; n.b = rs[4:0]; end
      6'h06: begin n.aluc = 2'b01; n.b = rs[4:0]; end
      6'h07: begin n.aluc = 2'b00; n.b = rs[4:0]; end
      default: begin n.illegal = 1'b1; return n; end
    endcase
    n.valid = 1'b1;
    n.a     = rt;
    n.rd    = bus.id_rd;
    n.wen   = (bus.id_rd != 5'd0);
    return n;
  endfunction

  task automatic set_id(input logic v, input logic [5:0] f, input logic [4:0] sh,
                        input logic [4:0] rsn, input logic [4:0] rtn, input logic [4:0] rd,
                        input logic [31:0] rsv, input logic [31:0] rtv);
    bus.id_valid  = v;
    bus.id_funct  = f;
    bus.id_shamt  = sh;
    bus.id_rs_num = rsn;
    bus.id_rt_num = rtn;
    bus.id_rd     = rd;
    bus.id_rs_val = rsv;
    bus.id_rt_val = rtv;
  endtask

  task automatic set_ctl(input logic st, input logic fl);
    bus.ex_stall = st;
    bus.flush    = fl;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] erd, input logic [31:0] ed,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] md);
    bus.exm_wen  = ew;
    bus.exm_rd   = erd;
    bus.exm_data = ed;
    bus.mwb_wen  = mw;
    bus.mwb_rd   = mrd;
    bus.mwb_data = md;
  endtask

  // Expected result enters the scoreboard at drive time and is retired after the edge.
  task automatic cycle(input string tag);
    exp_t e;
    e = model(cur);
    sbq.push_back(e);
    cur = e;
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check_out(tag, e);
  endtask

  logic [5:0] functs [8];

  initial begin
    functs = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h05};
    rst = 1'b1;
    cur = '0;
    set_id(0, 6'h00, 0, 0, 0, 0, 0, 0);
    set_ctl(0, 0);
    set_fwd(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", '0);
    rst = 1'b0;

    set_id(1, 6'h00, 5'd7, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0000_1234);
    cycle("sll");

    #2;
    rst = 1'b1;
    #1;
    check_out("async_rst", '0);
    cur = '0;

    set_ctl(1, 0);
    @(posedge clk);
    #1;
    check_out("rst_stall", '0);

    set_ctl(0, 0);
    set_id(1, 6'h03, 5'd4, 5'd1, 5'd2, 5'd8, 32'h0, 32'hF000_0000);
    rst = 1'b0;
    cycle("rel_sra");

    set_id(1, 6'h04, 5'd0, 5'd2, 5'd3, 5'd5, 32'hFFFF_FFE3, 32'h1);
    cycle("sllv");
    set_id(1, 6'h04, 5'd0, 5'd2, 5'd3, 5'd0, 32'hFFFF_FFE3, 32'h1);
    cycle("sllv_rd0");

    set_fwd(1, 5'd7, 32'hAAAA_AAAA, 1, 5'd7, 32'h5555_5555);
    set_id(1, 6'h02, 5'd1, 5'd2, 5'd7, 5'd4, 32'h0, 32'h1234_5678);
    cycle("fwd_exm");
    set_fwd(0, 5'd7, 32'hAAAA_AAAA, 1, 5'd7, 32'h5555_5555);
    cycle("fwd_mwb");
    set_fwd(1, 5'd0, 32'hAAAA_AAAA, 1, 5'd0, 32'h5555_5555);
    set_id(1, 6'h02, 5'd1, 5'd2, 5'd0, 5'd4, 32'h0, 32'h1234_5678);
    cycle("fwd_r0");
    set_fwd(1, 5'd9, 32'h0000_0013, 0, 5'd0, 32'h0);
    set_id(1, 6'h07, 5'd0, 5'd9, 5'd3, 5'd6, 32'h0000_001F, 32'h8000_0001);
    cycle("fwd_rs");
    set_fwd(0, 0, 0, 0, 0, 0);

    set_id(1, 6'h02, 5'd9, 5'd1, 5'd2, 5'd10, 32'h0, 32'hDEAD_BEEF);
    cycle("srl_load");
    set_ctl(1, 0);
    for (int i = 0; i < 3; i++) begin
      set_id(1, 6'h00, 5'(i + 1), 5'd3, 5'd4, 5'(i + 11), 32'h0, 32'(i * 32'h1111));
      cycle("stall_hold");
    end
    set_ctl(1, 1);
    cycle("stall_flush");
    set_ctl(0, 0);

    set_id(1, 6'h20, 5'd3, 5'd1, 5'd2, 5'd9, 32'h0, 32'h77);
    cycle("illegal");
    set_ctl(1, 0);
    cycle("illegal_stall");
    set_ctl(0, 0);
    set_id(0, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    cycle("idle");

    set_id(1, 6'h00, 5'd0, 5'd1, 5'd2, 5'd12, 32'h0, 32'hCAFE_0001);
    cycle("sll_amt0");

    for (int i = 0; i < 60; i++) begin
      set_id($urandom_range(0, 3) != 0, functs[$urandom_range(0, 7)], 5'($urandom),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             $urandom, $urandom);
      set_ctl($urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
      set_fwd($urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom,
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom);
      cycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
